// File: rtl/forward_hazard_ctrl.sv
// EX-stage operand forwarding select and one-cycle load-use stall controller.
// Optional FWD_STALL_CNT_EN adds a saturating stall_cnt output.
module forward_hazard_ctrl #(
    parameter int unsigned REG_ADDR_W = 3
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_regwrite,
    input  logic                  id_memread,
    input  logic                  flush,
    output logic [1:0]            forwardA,
    output logic [1:0]            forwardB,
`ifdef FWD_STALL_CNT_EN
    output logic [15:0]           stall_cnt,
`endif
    output logic                  stall,
    output logic                  ex_bubble
);

    localparam logic [1:0] FWD_EX = 2'b10;
    localparam logic [1:0] FWD_WB = 2'b01;
    localparam logic [1:0] FWD_RF = 2'b00;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_e;

    state_e state_q, state_d;

    // WB-stage producers are covered by register-file write-before-read, so
    // only the EX and MEM entries are kept for forwarding decisions.
    logic                  ex_rw_q, ex_rw_d;
    logic                  ex_mr_q, ex_mr_d;
    logic [REG_ADDR_W-1:0] ex_rd_q, ex_rd_d;
    logic                  mem_rw_q;
    logic [REG_ADDR_W-1:0] mem_rd_q;
    logic [1:0]            fwd_a_q, fwd_a_d;
    logic [1:0]            fwd_b_q, fwd_b_d;
    logic                  bubble_q, bubble_d;
    logic                  hazard_c;
    logic                  accept_c;

    function automatic logic [1:0] sel_fwd(
        input logic [REG_ADDR_W-1:0] rs,
        input logic                  ex_rw,
        input logic                  ex_mr,
        input logic [REG_ADDR_W-1:0] ex_rd,
        input logic                  mem_rw,
        input logic [REG_ADDR_W-1:0] mem_rd
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (rs != '0 && ex_rw && !ex_mr && ex_rd == rs) begin
            sel = FWD_EX;
        end else if (rs != '0 && mem_rw && mem_rd == rs) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

    // Hazard detection, next-state and next-entry logic.
    always_comb begin
        state_d  = state_q;
        hazard_c = id_valid && !flush && ex_mr_q && ex_rw_q && (ex_rd_q != '0) &&
                   ((ex_rd_q == id_rs1) || (ex_rd_q == id_rs2));
        accept_c = id_valid && !flush && !hazard_c;
        ex_rw_d  = 1'b0;
        ex_mr_d  = 1'b0;
        ex_rd_d  = '0;
        fwd_a_d  = FWD_RF;
        fwd_b_d  = FWD_RF;
        bubble_d = 1'b1;

        if (accept_c) begin
            ex_rw_d  = id_regwrite;
            ex_mr_d  = id_memread;
            ex_rd_d  = id_rd;
            fwd_a_d  = sel_fwd(id_rs1, ex_rw_q, ex_mr_q, ex_rd_q, mem_rw_q, mem_rd_q);
            fwd_b_d  = sel_fwd(id_rs2, ex_rw_q, ex_mr_q, ex_rd_q, mem_rw_q, mem_rd_q);
            bubble_d = 1'b0;
        end

        case (state_q)
            RUN:     if (hazard_c) state_d = STALL;
            STALL:   state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= RUN;
            ex_rw_q  <= 1'b0;
            ex_mr_q  <= 1'b0;
            ex_rd_q  <= '0;
            mem_rw_q <= 1'b0;
            mem_rd_q <= '0;
            fwd_a_q  <= FWD_RF;
            fwd_b_q  <= FWD_RF;
            bubble_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            ex_rw_q  <= ex_rw_d;
            ex_mr_q  <= ex_mr_d;
            ex_rd_q  <= ex_rd_d;
            mem_rw_q <= ex_rw_q;
            mem_rd_q <= ex_rd_q;
            fwd_a_q  <= fwd_a_d;
            fwd_b_q  <= fwd_b_d;
            bubble_q <= bubble_d;
        end
    end

    assign forwardA  = fwd_a_q;
    assign forwardB  = fwd_b_q;
    assign ex_bubble = bubble_q;
    assign stall     = (state_q == STALL);

`ifdef FWD_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    // Saturating count of stall cycles.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            stall_cnt_q <= 16'h0000;
        end else if (stall && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_forward_hazard_ctrl.sv
// Directed vector bench for forward_hazard_ctrl: forwarding selects, load-use
// stall, flush interaction and asynchronous reset during a stall.
module tb_forward_hazard_ctrl;

    logic       clock;
    logic       resetn;
    logic       id_valid;
    logic [2:0] id_rs1;
    logic [2:0] id_rs2;
    logic [2:0] id_rd;
    logic       id_regwrite;
    logic       id_memread;
    logic       flush;
    logic [1:0] forwardA;
    logic [1:0] forwardB;
    logic       stall;
    logic       ex_bubble;
`ifdef FWD_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    forward_hazard_ctrl #(.REG_ADDR_W(3)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rd       (id_rd),
        .id_regwrite (id_regwrite),
        .id_memread  (id_memread),
        .flush       (flush),
        .forwardA    (forwardA),
        .forwardB    (forwardB),
`ifdef FWD_STALL_CNT_EN
        .stall_cnt   (stall_cnt),
`endif
        .stall       (stall),
        .ex_bubble   (ex_bubble)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       v;
        logic [2:0] rs1;
        logic [2:0] rs2;
        logic [2:0] rd;
        logic       rw;
        logic       mr;
        logic       fl;
        logic [1:0] fa;
        logic [1:0] fb;
        logic       bub;
        logic       stl;
    } vec_t;

    localparam int NVEC = 25;
    vec_t tv [NVEC];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(input logic v, input logic [2:0] rs1, input logic [2:0] rs2,
                                input logic [2:0] rd, input logic rw, input logic mr,
                                input logic fl, input logic [1:0] fa, input logic [1:0] fb,
                                input logic bub, input logic stl);
        vec_t t;
        t.v = v; t.rs1 = rs1; t.rs2 = rs2; t.rd = rd; t.rw = rw; t.mr = mr; t.fl = fl;
        t.fa = fa; t.fb = fb; t.bub = bub; t.stl = stl;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string nm, input logic [1:0] fa, input logic [1:0] fb,
                              input logic bub, input logic stl);
        n_vec++;
        chk({nm, ".forwardA"}, 16'(forwardA), 16'(fa));
        chk({nm, ".forwardB"}, 16'(forwardB), 16'(fb));
        chk({nm, ".ex_bubble"}, 16'(ex_bubble), 16'(bub));
        chk({nm, ".stall"}, 16'(stall), 16'(stl));
    endtask

    task automatic drive(input logic v, input logic [2:0] rs1, input logic [2:0] rs2,
                         input logic [2:0] rd, input logic rw, input logic mr, input logic fl);
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_regwrite = rw; id_memread = mr; flush = fl;
        @(posedge clock);
        #1;
    endtask

    initial begin
        //            v  rs1   rs2   rd    rw mr fl  fa     fb     bub stl
        tv[0]  = mk(1, 3'd5, 3'd6, 3'd1, 1, 0, 0, 2'b00, 2'b00, 0, 0);
        tv[1]  = mk(1, 3'd1, 3'd2, 3'd7, 1, 0, 0, 2'b10, 2'b00, 0, 0);
        tv[2]  = mk(1, 3'd0, 3'd0, 3'd3, 1, 0, 0, 2'b00, 2'b00, 0, 0);
        tv[3]  = mk(1, 3'd5, 3'd6, 3'd5, 1, 0, 0, 2'b00, 2'b00, 0, 0);
        tv[4]  = mk(1, 3'd4, 3'd3, 3'd6, 1, 0, 0, 2'b00, 2'b01, 0, 0);
        tv[5]  = mk(1, 3'd0, 3'd0, 3'd2, 1, 0, 0, 2'b00, 2'b00, 0, 0);
        tv[6]  = mk(1, 3'd0, 3'd0, 3'd2, 1, 0, 0, 2'b00, 2'b00, 0, 0);
        tv[7]  = mk(1, 3'd2, 3'd2, 3'd5, 1, 0, 0, 2'b10, 2'b10, 0, 0);
        tv[8]  = mk(1, 3'd2, 3'd5, 3'd0, 0, 0, 0, 2'b01, 2'b10, 0, 0);
        // load-use: LOAD r4, then ADD rs2=r4 held across the stall
        tv[9]  = mk(1, 3'd5, 3'd0, 3'd4, 1, 1, 0, 2'b01, 2'b00, 0, 0);
        tv[10] = mk(1, 3'd1, 3'd4, 3'd1, 1, 0, 0, 2'b00, 2'b00, 1, 1);
        tv[11] = mk(1, 3'd1, 3'd4, 3'd1, 1, 0, 0, 2'b00, 2'b01, 0, 0);
        tv[12] = mk(1, 3'd4, 3'd1, 3'd0, 0, 0, 0, 2'b00, 2'b10, 0, 0);
        // rd=0 producers never forward or stall
        tv[13] = mk(1, 3'd3, 3'd3, 3'd0, 1, 0, 0, 2'b00, 2'b00, 0, 0);
        tv[14] = mk(1, 3'd0, 3'd0, 3'd0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        tv[15] = mk(1, 3'd0, 3'd0, 3'd0, 1, 1, 0, 2'b00, 2'b00, 0, 0);
        tv[16] = mk(1, 3'd0, 3'd0, 3'd3, 1, 0, 0, 2'b00, 2'b00, 0, 0);
        tv[17] = mk(0, 3'd3, 3'd3, 3'd3, 1, 0, 0, 2'b00, 2'b00, 1, 0);
        // stall then flush during the stall cycle
        tv[18] = mk(1, 3'd3, 3'd0, 3'd5, 1, 1, 0, 2'b01, 2'b00, 0, 0);
        tv[19] = mk(1, 3'd5, 3'd0, 3'd6, 1, 0, 0, 2'b00, 2'b00, 1, 1);
        tv[20] = mk(1, 3'd5, 3'd0, 3'd6, 1, 0, 1, 2'b00, 2'b00, 1, 0);
        tv[21] = mk(1, 3'd5, 3'd0, 3'd6, 1, 0, 0, 2'b00, 2'b00, 0, 0);
        // flush in the same cycle the hazard would be detected
        tv[22] = mk(1, 3'd0, 3'd0, 3'd6, 1, 1, 0, 2'b00, 2'b00, 0, 0);
        tv[23] = mk(1, 3'd6, 3'd0, 3'd1, 1, 0, 1, 2'b00, 2'b00, 1, 0);
        tv[24] = mk(1, 3'd6, 3'd6, 3'd1, 1, 0, 0, 2'b01, 2'b01, 0, 0);

        resetn = 1'b0;
        id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
        id_regwrite = 1'b0; id_memread = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_outs("reset", 2'b00, 2'b00, 1'b1, 1'b0);
`ifdef FWD_STALL_CNT_EN
        chk("reset.stall_cnt", stall_cnt, 16'd0);
`endif
        resetn = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            drive(tv[i].v, tv[i].rs1, tv[i].rs2, tv[i].rd, tv[i].rw, tv[i].mr, tv[i].fl);
            check_outs($sformatf("vec%0d", i), tv[i].fa, tv[i].fb, tv[i].bub, tv[i].stl);
`ifdef FWD_STALL_CNT_EN
            if (i == 11) chk("vec11.stall_cnt", stall_cnt, 16'd1);
`endif
        end
`ifdef FWD_STALL_CNT_EN
        chk("table.stall_cnt", stall_cnt, 16'd2);
`endif

        // Asynchronous reset in the middle of a stall cycle.
        drive(1, 3'd0, 3'd0, 3'd4, 1, 1, 0);
        check_outs("rst_load", 2'b00, 2'b00, 1'b0, 1'b0);
        drive(1, 3'd0, 3'd4, 3'd2, 1, 0, 0);
        check_outs("rst_stall", 2'b00, 2'b00, 1'b1, 1'b1);
        #2;
        resetn = 1'b0;
        #1;
        check_outs("rst_async", 2'b00, 2'b00, 1'b1, 1'b0);
`ifdef FWD_STALL_CNT_EN
        chk("rst_async.stall_cnt", stall_cnt, 16'd0);
`endif
        @(posedge clock);
        #1;
        resetn = 1'b1;
        // Held consumer after reset: pipeline is empty so no forwarding.
        drive(1, 3'd0, 3'd4, 3'd2, 1, 0, 0);
        check_outs("post_rst", 2'b00, 2'b00, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
